// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of a sampled PWM input, flags a stuck input.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to add a 3-cycle stability filter before edge detection.
module pwm_capture #(
    parameter int unsigned RESOLUTION = 10,
    parameter int unsigned CNT_W      = RESOLUTION + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic             timeout,
    output logic             dc_level
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic             s, s_d_q;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt_q, hi_lat_q;
    logic             cnt_run, latch_hi, publish, to_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] stab_q;
    logic       filt_q;

    // filt_q follows sync2_q only after the new level has been seen on 3 consecutive cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_q <= 2'd0;
            filt_q <= 1'b0;
        end else if (sync2_q != filt_q) begin
            if (stab_q == 2'd2) begin
                filt_q <= sync2_q;
                stab_q <= 2'd0;
            end else begin
                stab_q <= stab_q + 2'd1;
            end
        end else begin
            stab_q <= 2'd0;
        end
    end

    assign s = filt_q;
`else
    assign s = sync2_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s_d_q <= 1'b0;
        else     s_d_q <= s;
    end

    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (rise) state_d = StHigh;
            StHigh: begin
                if (fall)                 state_d = StLow;
                else if (cnt_q == CntMax) state_d = StIdle;
            end
            StLow: begin
                if (rise)                 state_d = StHigh;
                else if (cnt_q == CntMax) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // An edge in the same cycle as the counter limit takes priority over the timeout
    always_comb begin
        cnt_run  = 1'b0;
        latch_hi = 1'b0;
        publish  = 1'b0;
        to_hit   = 1'b0;
        unique case (state_q)
            StHigh: begin
                latch_hi = fall;
                to_hit   = !fall && (cnt_q == CntMax);
                cnt_run  = !to_hit;
            end
            StLow: begin
                publish = rise;
                to_hit  = !rise && (cnt_q == CntMax);
                cnt_run = !to_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            hi_lat_q   <= '0;
            high_time  <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            dc_level   <= 1'b0;
        end else begin
            meas_valid <= publish;
            if (rise)         cnt_q <= CntOne;
            else if (cnt_run) cnt_q <= cnt_q + CntOne;
            if (latch_hi) hi_lat_q <= cnt_q;
            if (publish) begin
                high_time <= hi_lat_q;
                period    <= cnt_q;
                timeout   <= 1'b0;
            end
            if (to_hit) begin
                timeout  <= 1'b1;
                dc_level <= s;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: timestamp-based reference model plus literal scenario checks.
module tb_pwm_capture;

    localparam int RES = 10;
    localparam int CW  = RES + 1;
    localparam int MAX = (1 << CW) - 1;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_in;
    logic [CW-1:0] high_time, period;
    logic          meas_valid, timeout, dc_level;

    pwm_capture #(.RESOLUTION(RES), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .high_time (high_time),
        .period    (period),
        .meas_valid(meas_valid),
        .timeout   (timeout),
        .dc_level  (dc_level)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: works on time stamps of the (delayed, optionally filtered) input edges
    int m_ht, m_per, rise_n, fall_n, n;
    bit m_valid, m_to, m_dc, tracking;
    bit p_last, sh1, sh2, sh3, l1, l2;

    task automatic model_reset();
        m_ht = 0; m_per = 0; m_valid = 0; m_to = 0; m_dc = 0;
        tracking = 0; rise_n = 0; fall_n = 0; n = 0;
        p_last = 0; sh1 = 0; sh2 = 0; sh3 = 0; l1 = 0; l2 = 0;
    endtask

    task automatic model_step();
        bit s_now, l_filt, l_now, lvl, prv;
        n++;
        s_now  = p_last;
        p_last = pwm_in;
        l_filt = (sh1 == sh2 && sh2 == sh3 && sh1 != l1) ? sh1 : l1;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        l_now = l_filt;
`else
        l_now = s_now;
`endif
        sh3 = sh2; sh2 = sh1; sh1 = s_now;
        lvl = l1; prv = l2;
        l2 = l1; l1 = l_now;
        m_valid = 0;
        if (tracking) begin
            if (lvl && !prv) begin
                m_ht = fall_n - rise_n; m_per = n - rise_n;
                m_valid = 1; m_to = 0; rise_n = n;
            end else if (!lvl && prv) begin
                fall_n = n;
            end else if (n - rise_n == MAX) begin
                m_to = 1; m_dc = lvl; tracking = 0;
            end
        end else if (lvl && !prv) begin
            tracking = 1; rise_n = n;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scenario bookkeeping observed by the compare process
    bit lit_en = 0, gl_watch = 0, gl_got = 0, to_prev = 0;
    int lit_ht = 0, lit_per = 0, nvalid = 0, gl_ht = 0, to_cyc = -1, rise_smp = 0;

    initial forever begin
        @(negedge clk);
        checks++;
        if (meas_valid !== m_valid || timeout !== m_to || dc_level !== m_dc ||
            high_time !== CW'(m_ht) || period !== CW'(m_per)) begin
            failures++;
            $display("FAIL model cyc=%0d got v=%b to=%b dc=%b ht=%0d per=%0d expected v=%b to=%b dc=%b ht=%0d per=%0d",
                     cyc, meas_valid, timeout, dc_level, high_time, period,
                     m_valid, m_to, m_dc, m_ht, m_per);
        end
        if (meas_valid === 1'b1) begin
            nvalid++;
            if (lit_en) begin
                check("lit_high_time", int'(high_time), lit_ht);
                check("lit_period", int'(period), lit_per);
                check("model_high_time", m_ht, lit_ht);
            end
            if (gl_watch && !gl_got) begin
                gl_got = 1;
                gl_ht  = int'(high_time);
            end
        end
        if (timeout === 1'b1 && !to_prev) to_cyc = cyc;
        to_prev = (timeout === 1'b1);
    end

    task automatic lvl(input bit v, input int cycles);
        if (v && !pwm_in) rise_smp = cyc + 1;
        pwm_in = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic periods(input int hi, input int lo, input int k);
        repeat (k) begin
            lvl(1'b1, hi);
            lvl(1'b0, lo);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_high_time"}, int'(high_time), 0);
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_valid"}, int'(meas_valid), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
        check({tag, "_dc_level"}, int'(dc_level), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 50% duty: first valid only after the second rise
        lit_en = 1; lit_ht = 512; lit_per = 1024; nvalid = 0;
        lvl(1'b1, 512); lvl(1'b0, 512);
        check("first_period_no_valid", nvalid, 0);
        periods(512, 512, 4);
        check("valid_count_512", nvalid, 4);

        // Stuck low
        lit_en = 0; to_cyc = -1;
        lvl(1'b0, MAX + 100);
        check("timeout_low", int'(timeout), 1);
        check("dc_level_low", int'(dc_level), 0);
        check("timeout_low_delay", to_cyc - rise_smp, MAX + LAT);
        check("hold_high_time", int'(high_time), 512);
        check("hold_period", int'(period), 1024);

        // Duty 123 restart: timeout clears only with the next valid
        lit_en = 1; lit_ht = 123; lit_per = 1024; nvalid = 0;
        lvl(1'b1, 123);
        check("timeout_kept_first_rise", int'(timeout), 1);
        lvl(1'b0, 901);
        periods(123, 901, 3);
        check("valid_count_123", nvalid, 3);
        check("timeout_cleared", int'(timeout), 0);

        // Stuck high
        to_cyc = -1;
        lvl(1'b1, MAX + 100);
        lit_en = 0;
        check("valid_count_123_final", nvalid, 4);
        check("timeout_high", int'(timeout), 1);
        check("dc_level_high", int'(dc_level), 1);
        check("timeout_high_delay", to_cyc - rise_smp, MAX + LAT);

        // Reset during a high phase, released during the following low phase
        lvl(1'b0, 20);
        lit_en = 1; lit_ht = 512; lit_per = 1024;
        periods(512, 512, 3);
        lvl(1'b1, 200);
        #3 rst = 1'b1; nvalid = 0;
        #1 check_zero_outputs("midrst");
        @(negedge clk);
        lvl(1'b1, 311);
        lvl(1'b0, 100);
        rst = 1'b0;
        lvl(1'b0, 412);
        periods(512, 512, 1);
        check("post_reset_first_no_valid", nvalid, 0);
        periods(512, 512, 2);
        check("post_reset_valid_count", nvalid, 2);

        // One-cycle low glitch inside a high phase
        lvl(1'b1, 100);
        lit_en = 0; gl_watch = 1;
        lvl(1'b1, 100);
        lvl(1'b0, 1);
        lvl(1'b1, 311);
        lvl(1'b0, 512);
        lvl(1'b1, 50);
        gl_watch = 0;
        check("glitch_valid_seen", int'(gl_got), 1);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        check("glitch_filtered_high_time", gl_ht, 512);
`else
        check("glitch_short_high_time", int'(gl_ht < 512), 1);
`endif

        // Random periods checked cycle-by-cycle against the model
        nvalid = 0;
        repeat (12) periods(int'($urandom_range(900, 4)), int'($urandom_range(900, 4)), 1);
        lvl(1'b1, 20);
        check("random_valid_count", nvalid, 12);
        check("random_no_timeout", int'(timeout), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Downstream measurement stage for the PWM generator. Samples a PWM waveform, measures high time and period in clock cycles, and publishes each completed measurement with a one-cycle valid strobe. Detects a stuck (DC) input by counter timeout. Used for loopback checking of the generator and for decoding external PWM.

Parameters:
RESOLUTION, 10, resolution of the PWM being measured; nominal period 2^RESOLUTION cycles
CNT_W, RESOLUTION+1, width of the internal counter and measurement outputs; timeout occurs at 2^CNT_W-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
pwm_in  input  1  PWM waveform, asynchronous to clk
high_time  output  CNT_W  cycles pwm was high in the last complete period
period  output  CNT_W  cycles from rising edge to next rising edge
meas_valid  output  1  one-cycle pulse: high_time/period just updated
timeout  output  1  sticky: no edge seen for 2^CNT_W-1 cycles
dc_level  output  1  synchronized pwm level captured at timeout

Behaviour:
- Reset (async, rst=1): sync flops, edge register, cnt, hi_lat, high_time, period = 0; meas_valid=0; timeout=0; dc_level=0; FSM=IDLE.
- Input path: 2-flop synchronizer -> s; s_d = s delayed 1 cycle. rise = s & ~s_d; fall = ~s & s_d. Edge-detect latency 3 cycles from pwm_in edge; equal for both edges, so measurements are unaffected.
- cnt: on rise, cnt<=1; otherwise, in HIGH/LOW, cnt<=cnt+1. At a fall, cnt holds the high-cycle count H; at the next rise it holds the period P.
- FSM states:
  - IDLE: wait for rise -> HIGH (cnt<=1). A fall in IDLE is ignored.
  - HIGH: on fall, hi_lat<=cnt -> LOW.
  - LOW: on rise, high_time<=hi_lat, period<=cnt, meas_valid<=1 for exactly the next cycle, timeout<=0, cnt<=1 -> HIGH.
- First rise after reset or after a timeout never produces meas_valid. The first valid follows the second rise.
- Timeout: in HIGH or LOW, when cnt reaches 2^CNT_W-1 with no edge, assert timeout, set dc_level<=s, go to IDLE, and hold cnt. high_time/period keep their last values. timeout stays set until the next meas_valid.
- Registered outputs hold between measurements. high_time <= period always holds for a valid measurement.
- Reset mid-operation: everything returns to reset values immediately. Any partial measurement is discarded.
- An edge coincident with the timeout cycle: the edge wins (no timeout).

Optional Feature:
Macro PWM_CAPTURE_GLITCH_FILTER_EN.
- Defined: a 3-cycle stability filter sits between the synchronizer and the edge detector. s changes only after the synchronized input has held a new level for 3 consecutive cycles. Pulses or gaps shorter than 3 cycles are suppressed. Latency rises by 3 cycles on both edges, so measurements of clean signals are unchanged.
- Undefined: no filter; s is the synchronizer output directly.

Test Plan:
- Generator RESOLUTION=10, DUTY=512 driving pwm_in -> from the 2nd period on, meas_valid once per 1024 cycles with high_time=512, period=1024; timeout=0.
- Generator DUTY=123 -> high_time=123, period=1024 every period; no meas_valid after the first rise only.
- pwm_in held 0 after two valid periods -> timeout=1, dc_level=0 exactly 2047 cycles after the last rise; high_time/period stay 512/1024. Restart PWM -> timeout clears at the next meas_valid.
- pwm_in held 1 (DUTY=1024 equivalent) -> timeout=1, dc_level=1 2047 cycles after the last rise.
- rst pulsed mid-high-phase -> all outputs 0 immediately. The next valid appears only after two further rising edges, with correct values.
- With PWM_CAPTURE_GLITCH_FILTER_EN, inject a 1-cycle low glitch in the high phase -> high_time=512 is unaffected. Without the macro, the same glitch gives a spurious measurement with high_time < 512.
